// File: rtl/interface_pkg.sv
// Shared AHB transfer/burst encodings and burst helper functions used by the
// I-cache line-fill read path.
package interface_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_types_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_types_e;

  localparam int BEAT_CNT_W = 5;

  // Undefined-length INCR is treated as a fixed 4-beat line fill.
  function automatic logic [BEAT_CNT_W-1:0] burst_len(input logic [2:0] hburst);
    logic [BEAT_CNT_W-1:0] len;
    case (hburst)
      SINGLE:                len = 5'd1;
      INCR, WRAP4, INCR4:    len = 5'd4;
      WRAP8, INCR8:          len = 5'd8;
      default:               len = 5'd16;
    endcase
    return len;
  endfunction

  function automatic logic is_wrap(input logic [2:0] hburst);
    return (hburst == WRAP4) || (hburst == WRAP8) || (hburst == WRAP16);
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Combinational next-beat address for a 4-byte-beat AHB burst: linear
// increment for INCR types, wrap inside the len*4-aligned block for WRAP types.
module burst_addr_gen
  import interface_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]     cur_addr,
  input  logic [2:0]            burst,
  input  logic [BEAT_CNT_W-1:0] len,
  output logic [ADDR_W-1:0]     next_addr
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr_addr = cur_addr + ADDR_W'(4);
    wrap_mask = ADDR_W'({len, 2'b00}) - ADDR_W'(1);
    if (is_wrap(burst)) begin
      next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

endmodule

// File: rtl/transfer_handler.sv
// AHB read-burst sequencer for I-cache line fills: accepts one NONSEQ read,
// walks the burst addresses and presents each completed beat for one cycle.
module transfer_handler
  import interface_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [2:0]        hburst,
  input  logic [1:0]        htrans,
  output logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic [1:0]        trans_out
);

  // Beat handshake: a beat completes on any rising edge in BURST with
  // hready=1; trans_out != IDLE marks the single cycle that beat is valid.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
  logic [2:0]            burst_q, burst_d;
  logic [BEAT_CNT_W-1:0] len_q, len_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]     read_addr_q, read_addr_d;
  logic [DATA_W-1:0]     read_data_q, read_data_d;
  logic [1:0]            trans_q, trans_d;
  logic [ADDR_W-1:0]     next_addr;

  // Write data and the byte offset of the request address carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{hwdata, addr[1:0]};

  burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .cur_addr (cur_addr_q),
    .burst    (burst_q),
    .len      (len_q),
    .next_addr(next_addr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      burst_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      read_addr_q <= '0;
      read_data_q <= '0;
      trans_q     <= IDLE;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      burst_q     <= burst_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      read_addr_q <= read_addr_d;
      read_data_q <= read_data_d;
      trans_q     <= trans_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    burst_d     = burst_q;
    len_d       = len_q;
    beat_d      = beat_q;
    read_addr_d = read_addr_q;
    read_data_d = read_data_q;
    trans_d     = IDLE;

    case (state_q)
      ST_IDLE: begin
        if ((htrans == NONSEQ) && !hwrite) begin
          cur_addr_d = {addr[ADDR_W-1:2], 2'b00};
          burst_d    = hburst;
          len_d      = burst_len(hburst);
          beat_d     = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        // Request inputs are ignored here; only hready advances the burst.
        if (hready) begin
          read_addr_d = cur_addr_q;
          read_data_d = hrdata;
          trans_d     = (beat_q == '0) ? NONSEQ : SEQ;
          beat_d      = beat_q + 5'd1;
          cur_addr_d  = next_addr;
          if (beat_q == len_q - 5'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign read_addr = read_addr_q;
  assign read_data = read_data_q;
  assign trans_out = trans_q;

endmodule

// File: tb/tb_transfer_handler.sv
// Directed bench for transfer_handler: a per-cycle vector table of inputs and
// hand-computed outputs, plus a hand-written reset-mid-burst sequence.
module tb_transfer_handler;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic [1:0]  trans_out;

  int tests_run = 0;
  int tests_failed = 0;

  transfer_handler #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .addr     (addr),
    .hwrite   (hwrite),
    .hrdata   (hrdata),
    .hready   (hready),
    .hwdata   (hwdata),
    .hburst   (hburst),
    .htrans   (htrans),
    .read_addr(read_addr),
    .read_data(read_data),
    .trans_out(trans_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hburst;
    logic [31:0] addr;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  exp_trans;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_WRAP4 = 3'd2, B_INCR4 = 3'd3,
                         B_WRAP8 = 3'd4, B_INCR8 = 3'd5;

  task automatic add_vec(input logic [1:0] ht, input logic hw, input logic [2:0] hb,
                         input logic [31:0] a, input logic rdy, input logic [31:0] rd,
                         input logic [1:0] et, input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.htrans = ht; v.hwrite = hw; v.hburst = hb; v.addr = a;
    v.hready = rdy; v.hrdata = rd;
    v.exp_trans = et; v.exp_addr = ea; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  // driver: apply on the falling edge, well away from the active edge
  task automatic drive(input logic [1:0] ht, input logic hw, input logic [2:0] hb,
                       input logic [31:0] a, input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    htrans = ht; hwrite = hw; hburst = hb; addr = a; hready = rdy; hrdata = rd;
    hwdata = $urandom;
  endtask

  // scoreboard comparison
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] et,
                            input logic [31:0] ea, input logic [31:0] ed);
    check({tag, ".trans_out"}, {30'd0, trans_out}, {30'd0, et});
    check({tag, ".read_addr"}, read_addr, ea);
    check({tag, ".read_data"}, read_data, ed);
  endtask

  logic [31:0] incr8_a [8];
  logic [31:0] wrap8_a [8];

  initial begin
    incr8_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                32'h0000_0008, 32'h0000_000C, 32'h0000_0010, 32'h0000_0014};
    wrap8_a = '{32'h0000_000C, 32'h0000_0010, 32'h0000_0014, 32'h0000_0018,
                32'h0000_001C, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

    // WRAP4 at 0x18, hready constant
    add_vec(T_NSEQ, 0, B_WRAP4, 32'h18, 1, 32'h0,        T_IDLE, 32'h0,  32'h0);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hA000_000A, T_NSEQ, 32'h18, 32'hA000_000A);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hB000_000B, T_SEQ,  32'h1C, 32'hB000_000B);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hC000_000C, T_SEQ,  32'h10, 32'hC000_000C);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hD000_000D, T_SEQ,  32'h14, 32'hD000_000D);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h1111_1111, T_IDLE, 32'h14, 32'hD000_000D);
    // INCR4 at 0x1C, hready low on alternate cycles
    add_vec(T_NSEQ, 0, B_INCR4, 32'h1C, 1, 32'h0,        T_IDLE, 32'h14, 32'hD000_000D);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 0, 32'hDEAD_0000, T_IDLE, 32'h14, 32'hD000_000D);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hE000_0001, T_NSEQ, 32'h1C, 32'hE000_0001);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 0, 32'hDEAD_0001, T_IDLE, 32'h1C, 32'hE000_0001);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hE000_0002, T_SEQ,  32'h20, 32'hE000_0002);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 0, 32'hDEAD_0002, T_IDLE, 32'h20, 32'hE000_0002);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hE000_0003, T_SEQ,  32'h24, 32'hE000_0003);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 0, 32'hDEAD_0003, T_IDLE, 32'h24, 32'hE000_0003);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hE000_0004, T_SEQ,  32'h28, 32'hE000_0004);
    // SINGLE accepted on the edge right after the last beat
    add_vec(T_NSEQ, 0, B_SINGLE, 32'h1234_5677, 1, 32'h0, T_IDLE, 32'h28, 32'hE000_0004);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'hF000_0001, T_NSEQ, 32'h1234_5674, 32'hF000_0001);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h2222_2222, T_IDLE, 32'h1234_5674, 32'hF000_0001);
    // INCR8 across the top of the address space, with ignored requests mid-burst
    add_vec(T_NSEQ, 0, B_INCR8, 32'hFFFF_FFF8, 1, 32'h0, T_IDLE, 32'h1234_5674, 32'hF000_0001);
    for (int k = 0; k < 8; k++) begin
      add_vec((k == 1 || k == 3) ? T_NSEQ : T_IDLE, (k == 3), (k == 1) ? B_SINGLE : B_INCR8,
              (k == 1) ? 32'h100 : 32'h0, 1, 32'h8000_0080 + k,
              (k == 0) ? T_NSEQ : T_SEQ, incr8_a[k], 32'h8000_0080 + k);
    end
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h3333_3333, T_IDLE, 32'h14, 32'h8000_0087);
    // write request, SEQ and BUSY in IDLE: no burst starts
    add_vec(T_NSEQ, 1, B_INCR4, 32'h40, 1, 32'h0,        T_IDLE, 32'h14, 32'h8000_0087);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h9999_9999, T_IDLE, 32'h14, 32'h8000_0087);
    add_vec(T_SEQ,  0, B_INCR4, 32'h40, 1, 32'h0,        T_IDLE, 32'h14, 32'h8000_0087);
    add_vec(T_BUSY, 0, B_INCR4, 32'h40, 1, 32'h0,        T_IDLE, 32'h14, 32'h8000_0087);
    add_vec(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h4444_4444, T_IDLE, 32'h14, 32'h8000_0087);

    rstn = 1'b0;
    htrans = T_IDLE; hwrite = 0; hburst = 0; addr = 0; hready = 1; hrdata = 0; hwdata = 0;
    repeat (2) @(posedge clk);
    #1 check_outs("reset", T_IDLE, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].htrans, vecs[i].hwrite, vecs[i].hburst, vecs[i].addr,
            vecs[i].hready, vecs[i].hrdata);
      @(posedge clk);
      #1 check_outs($sformatf("vec%0d", i), vecs[i].exp_trans, vecs[i].exp_addr, vecs[i].exp_data);
    end

    // WRAP8 at 0x34, reset asserted after beat 2
    drive(T_NSEQ, 0, B_WRAP8, 32'h34, 1, 32'h0);
    @(posedge clk);
    drive(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h5500_0001);
    @(posedge clk);
    #1 check_outs("wrap8_b1", T_NSEQ, 32'h34, 32'h5500_0001);
    drive(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h5500_0002);
    @(posedge clk);
    #1 check_outs("wrap8_b2", T_SEQ, 32'h38, 32'h5500_0002);
    @(negedge clk);
    hrdata = 32'h5500_0003;
    rstn = 1'b0;
    #1 check_outs("mid_reset", T_IDLE, 32'h0, 32'h0);
    @(posedge clk);
    #1 check_outs("mid_reset_hold", T_IDLE, 32'h0, 32'h0);

    // release and start a fresh WRAP8 at 0x0C
    @(negedge clk);
    rstn = 1'b1;
    htrans = T_NSEQ; hwrite = 0; hburst = B_WRAP8; addr = 32'h0C; hready = 1; hrdata = 0;
    @(posedge clk);
    #1 check_outs("post_reset_accept", T_IDLE, 32'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      drive(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h6600_0000 + k);
      @(posedge clk);
      #1 check_outs($sformatf("post_reset_b%0d", k), (k == 0) ? T_NSEQ : T_SEQ,
                    wrap8_a[k], 32'h6600_0000 + k);
    end
    drive(T_IDLE, 0, B_SINGLE, 32'h0, 1, 32'h7777_7777);
    @(posedge clk);
    #1 check_outs("post_reset_end", T_IDLE, 32'h08, 32'h6600_0007);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
